// File: rtl/fan_pwm_sequencer.sv
// Fan PWM sequencer: Avalon-MM registers, kick/ramp spin-up FSM, prescaled 8-bit PWM, tach window counter.
// Optional macro FAN_TACH_STALL_EN adds the STALL state driven by an empty tach window.
//
// state | meaning
// OFF   | fan unpowered, duty 0
// KICK  | fan powered, full drive for KICK_PERIODS PWM periods
// RAMP  | duty steps by 1 per period toward target
// RUN   | duty holds at target
// STALL | tach window empty while driven; fan off until enable=0 (FAN_TACH_STALL_EN only)
module fan_pwm_sequencer #(
  parameter int KICK_PERIODS = 16,
  parameter int TACH_WINDOW  = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        tach_in,
  output logic        pwm_out,
  output logic        fan_en
);

  localparam int KICK_W = (KICK_PERIODS > 1) ? $clog2(KICK_PERIODS) : 1;
  localparam int WIN_W  = (TACH_WINDOW > 1) ? $clog2(TACH_WINDOW) : 1;
  localparam logic [KICK_W-1:0] KICK_LAST = KICK_W'(KICK_PERIODS - 1);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(TACH_WINDOW - 1);

  typedef enum logic [2:0] {
    S_OFF  = 3'd0,
    S_KICK = 3'd1,
    S_RAMP = 3'd2,
`ifdef FAN_TACH_STALL_EN
    S_RUN  = 3'd3,
    S_STALL = 3'd4
`else
    S_RUN  = 3'd3
`endif
  } state_t;

  logic              ctrl_en_q;
  logic [7:0]        target_q;
  logic [15:0]       presc_pend_q;
  logic [15:0]       presc_act_q;
  logic [15:0]       presc_cnt_q;
  logic [7:0]        pwm_cnt_q;
  logic              tach_meta_q;
  logic              tach_sync_q;
  logic              tach_prev_q;
  logic [15:0]       tach_cnt_q;
  logic [15:0]       tach_q;
  logic [WIN_W-1:0]  win_cnt_q;
  state_t            state_q;
  logic [7:0]        cur_duty_q;
  logic [KICK_W-1:0] kick_cnt_q;
  logic              fan_en_q;
  logic              pwm_out_q;
  logic              pwm_out_d;
  logic [31:0]       readdata_q;
  logic [31:0]       readdata_d;

  logic       wr_en;
  logic       ctrl_wr;
  logic       presc_wr;
  logic       en_eff;
  logic [7:0] target_eff;
  logic       tick;
  logic       period_end;
  logic       tach_rise;
  logic       tach_latch;
  logic [7:0] duty_step;
  logic       stall_bit;
  logic       unused_wdata;

  assign wr_en    = chipselect & ~write_n;
  assign ctrl_wr  = wr_en && (address == 2'd0);
  assign presc_wr = wr_en && (address == 2'd1);
  assign unused_wdata = &writedata[31:16];

  // A CTRL write is seen by the FSM on the same edge it lands in the register.
  assign en_eff     = ctrl_wr ? writedata[0]    : ctrl_en_q;
  assign target_eff = ctrl_wr ? writedata[15:8] : target_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_en_q    <= 1'b1;
      target_q     <= 8'h80;
      presc_pend_q <= '0;
    end else begin
      if (ctrl_wr) begin
        ctrl_en_q <= writedata[0];
        target_q  <= writedata[15:8];
      end
      if (presc_wr) begin
        presc_pend_q <= writedata[15:0];
      end
    end
  end

  assign tick       = (presc_cnt_q == 16'd0);
  assign period_end = tick && (pwm_cnt_q == 8'hFF);

  // Prescale down-counter; the written PRESC is adopted only at a period end.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_cnt_q <= '0;
      presc_act_q <= '0;
      pwm_cnt_q   <= '0;
    end else if (tick) begin
      pwm_cnt_q <= pwm_cnt_q + 8'd1;
      if (pwm_cnt_q == 8'hFF) begin
        presc_act_q <= presc_pend_q;
        presc_cnt_q <= presc_pend_q;
      end else begin
        presc_cnt_q <= presc_act_q;
      end
    end else begin
      presc_cnt_q <= presc_cnt_q - 16'd1;
    end
  end

  assign tach_rise  = tach_sync_q & ~tach_prev_q;
  assign tach_latch = period_end && (win_cnt_q == WIN_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tach_meta_q <= 1'b0;
      tach_sync_q <= 1'b0;
      tach_prev_q <= 1'b0;
      tach_cnt_q  <= '0;
      tach_q      <= '0;
      win_cnt_q   <= '0;
    end else begin
      tach_meta_q <= tach_in;
      tach_sync_q <= tach_meta_q;
      tach_prev_q <= tach_sync_q;
      if (period_end) begin
        win_cnt_q <= (win_cnt_q == WIN_LAST) ? '0 : win_cnt_q + WIN_W'(1);
      end
      if (tach_latch) begin
        tach_q     <= tach_cnt_q;
        tach_cnt_q <= tach_rise ? 16'd1 : 16'd0;
      end else if (tach_rise && (tach_cnt_q != 16'hFFFF)) begin
        tach_cnt_q <= tach_cnt_q + 16'd1;
      end
    end
  end

  assign duty_step = (cur_duty_q < target_eff) ? cur_duty_q + 8'd1 : cur_duty_q - 8'd1;

`ifdef FAN_TACH_STALL_EN
  logic stall_q;
  logic stall_hit;
  logic stall_clr;

  assign stall_hit = tach_latch && (tach_cnt_q == 16'd0) && (cur_duty_q != 8'd0);
  assign stall_clr = wr_en && (address == 2'd3) && writedata[8];
  assign stall_bit = stall_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= 1'b0;
    end else if (en_eff && (state_q == S_RUN) && stall_hit) begin
      stall_q <= 1'b1;
    end else if (stall_clr) begin
      stall_q <= 1'b0;
    end
  end
`else
  assign stall_bit = 1'b0;
`endif

  // KICK drives solidly high; elsewhere the duty compare applies (duty is 0 in OFF/STALL).
  assign pwm_out_d = en_eff && ((state_q == S_KICK) || (pwm_cnt_q < cur_duty_q));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_OFF;
      cur_duty_q <= '0;
      kick_cnt_q <= '0;
      fan_en_q   <= 1'b0;
      pwm_out_q  <= 1'b0;
    end else begin
      pwm_out_q <= pwm_out_d;
      if (!en_eff) begin
        state_q    <= S_OFF;
        cur_duty_q <= '0;
        fan_en_q   <= 1'b0;
      end else begin
        case (state_q)
          S_OFF: begin
            state_q    <= S_KICK;
            cur_duty_q <= 8'hFF;
            fan_en_q   <= 1'b1;
            kick_cnt_q <= KICK_LAST;
          end
          S_KICK: begin
            if (period_end) begin
              if (kick_cnt_q == '0) begin
                state_q <= S_RAMP;
              end else begin
                kick_cnt_q <= kick_cnt_q - KICK_W'(1);
              end
            end
          end
          S_RAMP: begin
            if (period_end) begin
              if (cur_duty_q == target_eff) begin
                state_q <= S_RUN;
              end else begin
                cur_duty_q <= duty_step;
                if (duty_step == target_eff) begin
                  state_q <= S_RUN;
                end
              end
            end
          end
          S_RUN: begin
`ifdef FAN_TACH_STALL_EN
            if (stall_hit) begin
              state_q    <= S_STALL;
              cur_duty_q <= '0;
              fan_en_q   <= 1'b0;
            end else if (period_end && (target_eff != cur_duty_q)) begin
              state_q <= S_RAMP;
            end
`else
            if (period_end && (target_eff != cur_duty_q)) begin
              state_q <= S_RAMP;
            end
`endif
          end
`ifdef FAN_TACH_STALL_EN
          S_STALL: begin
            cur_duty_q <= '0;
            fan_en_q   <= 1'b0;
          end
`endif
          default: begin
            state_q    <= S_OFF;
            cur_duty_q <= '0;
            fan_en_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      2'd0: begin
        readdata_d[0]    = ctrl_en_q;
        readdata_d[15:8] = target_q;
      end
      2'd1: readdata_d[15:0] = presc_pend_q;
      2'd2: readdata_d[15:0] = tach_q;
      default: begin
        readdata_d[7:0]  = cur_duty_q;
        readdata_d[8]    = stall_bit;
        readdata_d[11:9] = state_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q <= '0;
    end else begin
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign pwm_out  = pwm_out_q;
  assign fan_en   = fan_en_q;

endmodule

// File: tb/tb_fan_pwm_sequencer.sv
// Scoreboard bench for fan_pwm_sequencer: reads push expected data, a monitor pops and compares.
// Timeline assumes PRESC=0 (256-clock periods) until the PRESC step near the end.
module tb_fan_pwm_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        tach_in = 1'b0;
  logic        pwm_out;
  logic        fan_en;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;
  exp_t exp_q[$];

  fan_pwm_sequencer #(.KICK_PERIODS(16), .TACH_WINDOW(64)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .tach_in(tach_in), .pwm_out(pwm_out), .fan_en(fan_en)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: a read presented at a posedge is compared at the following negedge.
  initial begin : monitor
    logic fire;
    exp_t e;
    forever begin
      @(posedge clk);
      fire = reset_n && chipselect && write_n;
      @(negedge clk);
      if (fire) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rd_unexpected: readdata 0x%08h with no expected entry", readdata);
        end else begin
          e = exp_q.pop_front();
          if (readdata !== e.exp) begin
            errors++;
            $display("FAIL %s: readdata 0x%08h expected 0x%08h", e.name, readdata, e.exp);
          end
        end
      end
    end
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input string name, input logic [1:0] a, input logic [31:0] e);
    exp_t x;
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    x.name = name; x.exp = e;
    exp_q.push_back(x);
    @(negedge clk);
    chipselect = 1'b0;
  endtask

  // STATUS polled without chipselect so the scoreboard ignores it.
  task automatic poll_status(input string name, input logic [31:0] exp, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    address = 2'd3;
    @(negedge clk);
    while (readdata !== exp && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, readdata, exp);
  endtask

  task automatic count_high(output int hi);
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (pwm_out) hi++;
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Ten pulses in tach window 1 and in window 2, none in window 3.
  initial begin : tach_gen
    @(posedge reset_n);
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 10; i++) begin
        wait_cyc(1000 + w * 16000 + i * 1000);
        tach_in = 1'b1;
        repeat (20) @(negedge clk);
        tach_in = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  initial begin : main
    int lows;
    int hi;
    int n;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_readdata", readdata, 32'h0);
    check("rst_pwm", {31'b0, pwm_out}, 32'h0);
    check("rst_fan_en", {31'b0, fan_en}, 32'h0);
    reset_n = 1'b1;

    bus_read("ctrl_after_reset", 2'd0, 32'h0000_8001);
    bus_read("status_kick", 2'd3, 32'h0000_02FF);
    check("kick_fan_en", {31'b0, fan_en}, 32'h1);

    bus_write(2'd0, 32'h0000_8000);
    check("dis_fan_en", {31'b0, fan_en}, 32'h0);
    check("dis_pwm", {31'b0, pwm_out}, 32'h0);
    bus_read("status_off", 2'd3, 32'h0);
    bus_read("ctrl_off", 2'd0, 32'h0000_8000);
    bus_write(2'd0, 32'h0000_8001);

    wait_cyc(100);
    lows = 0;
    while (cyc < 4000) begin
      @(negedge clk);
      if (!pwm_out) lows++;
    end
    check("kick_pwm_low_count", lows, 0);
    check("kick_fan_en2", {31'b0, fan_en}, 32'h1);

    // Period ends at cycles 256*k; RAMP from PE16, one step per PE after that.
    wait_cyc(17000);
    bus_read("tach_win1", 2'd2, 32'd10);
    bus_read("status_ramp_205", 2'd3, 32'h0000_04CD);
    wait_cyc(33400);
    bus_read("tach_win2", 2'd2, 32'd10);
    bus_read("status_ramp_141", 2'd3, 32'h0000_048D);

    poll_status("run_reached", 32'h0000_0680, 5000);
    check("run_cycle", cyc, 36609);
    count_high(hi);
    check("pwm_high_128", hi, 128);

    bus_write(2'd0, 32'h0000_8201);
    bus_read("ctrl_target_82", 2'd0, 32'h0000_8201);
    poll_status("ramp_up_start", 32'h0000_0480, 600);
    poll_status("ramp_up_81", 32'h0000_0481, 600);
    poll_status("run_82", 32'h0000_0682, 600);
    count_high(hi);
    check("pwm_high_130", hi, 130);

    wait_cyc(49400);
    bus_read("tach_win3_zero", 2'd2, 32'h0);
`ifdef FAN_TACH_STALL_EN
    bus_read("status_stall", 2'd3, 32'h0000_0900);
    check("stall_fan_en", {31'b0, fan_en}, 32'h0);
    bus_write(2'd3, 32'h0000_0100);
    bus_read("status_stall_clr", 2'd3, 32'h0000_0800);
`else
    bus_read("status_no_stall", 2'd3, 32'h0000_0682);
    check("run_fan_en", {31'b0, fan_en}, 32'h1);
`endif

    bus_write(2'd1, 32'h0000_0003);
    bus_read("presc_rd", 2'd1, 32'h0000_0003);
    bus_write(2'd2, 32'h0000_1234);
    bus_read("tach_readonly", 2'd2, 32'h0);
    bus_read("presc_rd2", 2'd1, 32'h0000_0003);

`ifndef FAN_TACH_STALL_EN
    n = 0;
    while (!pwm_out && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("pwm_high_before_rst", {31'b0, pwm_out}, 32'h1);
`endif
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_pwm", {31'b0, pwm_out}, 32'h0);
    check("async_rst_fan_en", {31'b0, fan_en}, 32'h0);
    check("async_rst_readdata", readdata, 32'h0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    bus_read("ctrl_after_rerst", 2'd0, 32'h0000_8001);
    bus_read("presc_after_rerst", 2'd1, 32'h0);
    bus_read("tach_after_rerst", 2'd2, 32'h0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fan_pwm_sequencer.md
FAN_PWM_SEQUENCER -- requirements
Module: fan_pwm_sequencer

Interface
REQ-001 SHALL have parameter KICK_PERIODS, default 16: number of full-duty PWM periods applied at spin-up.
REQ-002 SHALL have parameter TACH_WINDOW, default 64: number of PWM periods per tachometer sample window.
REQ-003 SHALL have port clk, input, 1 bit: clock.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports address (input, 2 bits), chipselect (input, 1), write_n (input, 1) and writedata (input, 32): Avalon-MM slave write side.
REQ-006 SHALL have port readdata, output, 32 bits: registered Avalon-MM read data.
REQ-007 SHALL have port tach_in, input, 1 bit: asynchronous fan tachometer pulse.
REQ-008 SHALL have port pwm_out, output, 1 bit: fan PWM drive.
REQ-009 SHALL have port fan_en, output, 1 bit: fan power enable.

Function
REQ-010 SHALL decode a register write when chipselect=1 and write_n=0, taking effect at the next clk edge.
REQ-011 SHALL implement the register map as follows.
- Address 0 CTRL: bit 0 enable; bits 15:8 target duty. Read/write.
- Address 1 PRESC: bits 15:0, PWM prescaler. Read/write.
- Address 2 TACH: bits 15:0, last latched tach count. Read-only.
- Address 3 STATUS: bits 7:0 cur_duty; bit 8 stall flag; bits 11:9 state. Writing 1 to bit 8 clears the stall flag.
REQ-012 SHALL register readdata every cycle from the address decode, giving a 1-cycle read latency independent of chipselect; unused bits read 0.
REQ-013 SHALL advance an 8-bit PWM counter once every PRESC+1 clocks, wrapping from 255 to 0; a period-end event occurs at the step from 255.
REQ-014 SHALL drive pwm_out=1 while PWM counter < cur_duty; cur_duty=0 gives constant 0.
REQ-015 SHALL use states OFF=0, KICK=1, RAMP=2, RUN=3 and STALL=4.
REQ-016 SHALL behave in OFF with fan_en=0 and cur_duty=0, and go to KICK when enable=1.
REQ-017 SHALL behave in KICK with fan_en=1 and cur_duty=255, and go to RAMP after KICK_PERIODS period-ends.
REQ-018 SHALL, in RAMP, step cur_duty by ±1 toward target at each period-end, and enter RUN when cur_duty equals target.
REQ-019 SHALL, in RUN, return to RAMP at the next period-end on which target differs from cur_duty.
REQ-020 SHALL go to OFF on the next clock when enable=0 is written, from any state; this takes priority over every other transition.
REQ-021 SHALL make a target write coinciding with a period-end visible to that same period-end evaluation.
REQ-022 SHALL pass tach_in through a 2-FF synchronizer and count rising edges into a saturating 16-bit counter.
REQ-023 SHALL, every TACH_WINDOW period-ends, latch the counter into TACH and clear it; an edge in the latch cycle counts toward the new window.
REQ-024 SHALL hold PRESC changes until the next period-end; a PRESC write never truncates the current prescale count.

Reset
REQ-025 SHALL, on reset_n=0, immediately set: readdata=0, pwm_out=0, fan_en=0, state OFF, PWM/prescale/tach counters 0, TACH=0, stall flag 0, PRESC=0.
REQ-026 SHALL reset CTRL to enable=1, target=0x80, so the fan spins up (fail-safe) after reset release with no software action.
REQ-027 SHALL, on reset assertion mid-operation, drop pwm_out and fan_en to 0 asynchronously, without waiting for a clock.

Configuration
REQ-028 SHALL, with macro FAN_TACH_STALL_EN defined, move from RUN to STALL whenever a TACH latch yields 0 while cur_duty≠0.
- STALL: fan_en=0, cur_duty=0, stall flag set (sticky).
- Exit only via enable=0 to OFF.
REQ-029 SHALL, without FAN_TACH_STALL_EN, omit the STALL state; the stall flag reads 0 and the tach count has no effect on state.

Verification
REQ-030 SHALL cover reset release with PRESC=0: state KICK, pwm_out constantly 1 for 16×256 clocks, then duty steps down 255→128 over 127 periods, then RUN.
REQ-031 SHALL cover, in RUN at 0x80, a write of target 0x82: RAMP, then duty 0x81 then 0x82 on two successive period-ends, then RUN; pwm_out high 130 of 256 clocks.
REQ-032 SHALL cover a write of enable=0 mid-KICK: fan_en=0 and pwm_out=0 on the next clock; STATUS reads state 0.
REQ-033 SHALL cover 10 tach pulses per window with TACH_WINDOW=64: TACH reads 10 after each window; with no pulses and FAN_TACH_STALL_EN, STALL is entered, STATUS bit 8=1 and fan_en=0.
REQ-034 SHALL cover a read of address 1 after writing 0x0003: readdata=0x00000003 one clock after address is presented; address 2 writes are ignored.
REQ-035 SHALL cover reset_n asserted mid-RUN: pwm_out=0 and fan_en=0 with no clock edge; CTRL reads 0x00008001 after release.
